imem_loader: RTL and testbench

//  Writer side of the instruction memory that fetchStage reads. Receives a byte

---
 rtl/imem_loader.sv | 187 ++++++++++++++++++
 tb/tb_imem_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte stream into the instruction memory
// and holds the fetch stage in reset until the image is complete.
// Optional trailing checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 16,
   parameter bit HI_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        rxData,
   input  logic              rxValid,
   output logic              rxReady,
   output logic              memWrEn,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memData,
   output logic              fetchHold,
   output logic              loadDone,
   output logic              loadErr
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LEN  = 3'd1;
   localparam logic [2:0] S_B0   = 3'd2;
   localparam logic [2:0] S_B1   = 3'd3;
   localparam logic [2:0] S_WR   = 3'd4;
   localparam logic [2:0] S_DONE = 3'd6;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam logic [2:0] S_CHK  = 3'd5;
`endif

   logic [2:0]        state_q, state_d;
   logic [8:0]        index_q, index_d;
   logic [8:0]        count_q, count_d;
   logic [7:0]        byte0_q, byte0_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              wr_en_q, wr_en_d;
   logic              ready_q, ready_d;
   logic              hold_q, hold_d;
   logic              done_q, done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        sum_q, sum_d;
   logic              err_q, err_d;
`endif

   logic        accept;
   logic        last_word;
   logic [15:0] word;

   assign accept    = rxValid & ready_q;
   assign last_word = (index_q == count_q - 9'd1);
   assign word      = HI_FIRST ? {byte0_q, rxData} : {rxData, byte0_q};

   // NOTE: every next-state variable gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      index_d = index_q;
      count_d = count_q;
      byte0_d = byte0_q;
      addr_d  = addr_q;
      data_d  = data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d   = sum_q;
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_LEN;
               index_d = 9'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_d   = 8'd0;
               err_d   = 1'b0;
`endif
            end
         end
         S_LEN: begin
            if (accept) begin
               // A zero count byte encodes a full 256-word image.
               count_d = (rxData == 8'd0) ? 9'd256 : {1'b0, rxData};
               state_d = S_B0;
            end
         end
         S_B0: begin
            if (accept) begin
               byte0_d = rxData;
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_d   = sum_q + rxData;
`endif
               state_d = S_B1;
            end
         end
         S_B1: begin
            if (accept) begin
               data_d  = DATA_W'(word);
               addr_d  = index_q[ADDR_W-1:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_d   = sum_q + rxData;
`endif
               state_d = S_WR;
            end
         end
         S_WR: begin
            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = S_CHK;
`else
               state_d = S_DONE;
`endif
            end else begin
               index_d = index_q + 9'd1;
               state_d = S_B0;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (accept) begin
               err_d   = (8'(sum_q + rxData) != 8'd0);
               state_d = S_DONE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they are registered alongside it.
      ready_d = (state_d == S_LEN) || (state_d == S_B0) || (state_d == S_B1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      ready_d = ready_d || (state_d == S_CHK);
`endif
      wr_en_d = (state_d == S_WR);
      hold_d  = (state_d != S_DONE);
      done_d  = (state_d == S_DONE);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         index_q <= 9'd0;
         count_q <= 9'd0;
         byte0_q <= 8'd0;
         addr_q  <= '0;
         data_q  <= '0;
         wr_en_q <= 1'b0;
         ready_q <= 1'b0;
         hold_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         count_q <= count_d;
         byte0_q <= byte0_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wr_en_q <= wr_en_d;
         ready_q <= ready_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q <= 8'd0;
         err_q <= 1'b0;
      end else begin
         sum_q <= sum_d;
         err_q <= err_d;
      end
   end
   assign loadErr = err_q;
`else
   assign loadErr = 1'b0;
`endif

   assign rxReady   = ready_q;
   assign memWrEn   = wr_en_q;
   assign memAddr   = addr_q;
   assign memData   = data_q;
   assign fetchHold = hold_q;
   assign loadDone  = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized loads checked against a word-level model of the
// expected imem writes, completion flags and checksum result.
module tb_imem_loader;

   localparam int ADDR_W   = 8;
   localparam int DATA_W   = 16;
   localparam bit HI_FIRST = 1'b1;
   localparam int BUDGET   = 64;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [7:0]        rxData;
   logic              rxValid;
   logic              rxReady;
   logic              memWrEn;
   logic [ADDR_W-1:0] memAddr;
   logic [DATA_W-1:0] memData;
   logic              fetchHold;
   logic              loadDone;
   logic              loadErr;

   imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HI_FIRST(HI_FIRST)) dut (
      .clk(clk), .reset(reset), .start(start), .rxData(rxData), .rxValid(rxValid),
      .rxReady(rxReady), .memWrEn(memWrEn), .memAddr(memAddr), .memData(memData),
      .fetchHold(fetchHold), .loadDone(loadDone), .loadErr(loadErr)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         mon_e;
   logic [15:0] wq[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Every write strobe must match the next expected write, in order.
   always @(negedge clk) begin
      if (memWrEn === 1'b1) begin
         check("ready_in_wr", 32'(rxReady), 32'd0);
         if (exp_q.size() == 0) begin
            check("extra_wr", 32'(memWrEn), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 32'(memAddr), 32'(mon_e.addr));
            check("wr_data", 32'(memData), 32'(mon_e.data));
         end
      end
   end

   function automatic logic [7:0] byte_of(input logic [15:0] w, input int k);
      if (HI_FIRST) return (k == 0) ? w[15:8] : w[7:0];
      else          return (k == 0) ? w[7:0]  : w[15:8];
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Entered and left just after a falling edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int waited = 0;
      for (int i = 0; i < gap; i++) begin
         rxValid = 1'b0;
         rxData  = 8'($urandom);
         @(negedge clk);
      end
      rxValid = 1'b1;
      rxData  = b;
      while (rxReady !== 1'b1 && waited < BUDGET) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= BUDGET) check("rx_timeout", 32'(rxReady), 32'd1);
      @(negedge clk);
      rxValid = 1'b0;
   endtask

   task automatic run_load(input logic [15:0] words[$], input int min_gap, input int max_gap,
                           input bit bad_sum, input bit poke_start);
      logic [7:0] bytes[$];
      logic [7:0] sum = 8'd0;
      logic [7:0] chk;
      int         n = words.size();
      int         start_cyc;
      int         lat;
      int         waited = 0;
      logic       exp_err;
      int         exp_lat;
      wr_t        e;

      bytes.push_back(8'(n));
      for (int i = 0; i < n; i++) begin
         bytes.push_back(byte_of(words[i], 0));
         bytes.push_back(byte_of(words[i], 1));
         sum    = sum + words[i][15:8] + words[i][7:0];
         e.addr = ADDR_W'(i);
         e.data = words[i];
         exp_q.push_back(e);
      end
      chk = 8'(8'd0 - sum) + (bad_sum ? 8'd1 : 8'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      exp_err = bad_sum;
      exp_lat = 3 * n + 2;
`else
      exp_err = 1'b0;
      exp_lat = 3 * n + 1;
`endif

      pulse_start();
      start_cyc = cyc;
      check("hold_at_start", 32'(fetchHold), 32'd1);
      check("done_at_start", 32'(loadDone), 32'd0);
      check("err_at_start", 32'(loadErr), 32'd0);

      for (int i = 0; i < bytes.size(); i++) begin
         if (poke_start && i == 3) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         send_byte(bytes[i], int'($urandom_range(max_gap, min_gap)));
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(chk, int'($urandom_range(max_gap, min_gap)));
`else
      chk = 8'd0;
`endif

      while (loadDone !== 1'b1 && waited < BUDGET) begin
         @(negedge clk);
         waited++;
      end
      lat = cyc - start_cyc;
      check("load_done", 32'(loadDone), 32'd1);
      check("hold_released", 32'(fetchHold), 32'd0);
      check("ready_in_done", 32'(rxReady), 32'd0);
      check("load_err", 32'(loadErr), 32'(exp_err));
      check("missing_wr", 32'(exp_q.size()), 32'd0);
      if (max_gap == 0 && !poke_start) check("latency", 32'(lat), 32'(exp_lat));
      exp_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      rxValid = 1'b0;
      rxData  = 8'd0;
      @(negedge clk);
      check("rst_hold", 32'(fetchHold), 32'd1);
      check("rst_ready", 32'(rxReady), 32'd0);
      check("rst_wren", 32'(memWrEn), 32'd0);
      check("rst_done", 32'(loadDone), 32'd0);
      check("rst_addr", 32'(memAddr), 32'd0);
      check("rst_data", 32'(memData), 32'd0);
      check("rst_err", 32'(loadErr), 32'd0);
      reset = 1'b0;

      rxValid = 1'b1;
      rxData  = 8'hA5;
      repeat (3) @(negedge clk);
      check("idle_ready", 32'(rxReady), 32'd0);
      rxValid = 1'b0;

      wq = {};
      wq.push_back(16'h1234);
      wq.push_back(16'h1008);
      run_load(wq, 0, 0, 1'b0, 1'b0);
      run_load(wq, 3, 3, 1'b0, 1'b0);

      wq = {};
      for (int i = 0; i < 256; i++) wq.push_back(16'($urandom));
      run_load(wq, 0, 0, 1'b0, 1'b0);

      // Reset right after the first write of a four-word image.
      wq = {};
      for (int i = 0; i < 4; i++) wq.push_back(16'($urandom));
      mon_e.addr = '0;
      mon_e.data = wq[0];
      exp_q.push_back(mon_e);
      pulse_start();
      send_byte(8'd4, 0);
      send_byte(byte_of(wq[0], 0), 0);
      send_byte(byte_of(wq[0], 1), 0);
      check("mid_wren", 32'(memWrEn), 32'd1);
      reset   = 1'b1;
      rxValid = 1'b1;
      rxData  = byte_of(wq[1], 0);
      @(negedge clk);
      reset = 1'b0;
      check("mid_hold", 32'(fetchHold), 32'd1);
      check("mid_done", 32'(loadDone), 32'd0);
      check("mid_wren_off", 32'(memWrEn), 32'd0);
      check("mid_addr", 32'(memAddr), 32'd0);
      check("mid_ready", 32'(rxReady), 32'd0);
      repeat (4) @(negedge clk);
      rxValid = 1'b0;
      check("mid_pending", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      run_load(wq, 0, 1, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      wq = {};
      wq.push_back(16'h1234);
      run_load(wq, 0, 0, 1'b0, 1'b0);
      run_load(wq, 0, 0, 1'b1, 1'b0);
      run_load(wq, 0, 0, 1'b0, 1'b0);
`endif

      repeat (8) begin
         int n = int'($urandom_range(24, 1));
         wq = {};
         for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
         run_load(wq, 0, int'($urandom_range(2, 0)), 1'($urandom),
                  (n >= 2) && 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
